serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin an addition, sampled on clk.
REQ-005 SHALL have port: a_in  input  WIDTH  operand A, captured when start is accepted.
REQ-006 SHALL have port: b_in  input  WIDTH  operand B, captured when start is accepted.
REQ-007 SHALL have port: cin  input  1  carry-in, captured when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when a result becomes valid.
REQ-010 SHALL have port: sum  output  WIDTH  registered result of A+B+cin, modulo 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 SHALL be accepted, latching a_in, b_in and cin into shift/carry registers, clearing the bit counter, and moving to RUN.
REQ-014 start SHALL be ignored in RUN and DONE, with no effect on in-flight operands or results.
REQ-015 RUN: each cycle SHALL add the operand LSBs plus the carry register through one full-adder cell, shift the sum bit into the MSB of an internal sum shift register, shift both operands right by one, store the cell carry-out, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles SHALL load sum and cout from the internal registers and move to DONE.
REQ-017 Latency SHALL be WIDTH edges from the start-accepting edge to the edge that loads sum/cout and raises done.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-020 sum and cout SHALL hold the last result from DONE until the next result load; they SHALL NOT change during RUN.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide, and WIDTH=1 SHALL complete in one RUN cycle.
REQ-022 With start held high continuously, a new operation SHALL be accepted every WIDTH+2 cycles.

Reset
REQ-023 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear all shift, carry and counter registers.
REQ-024 Reset during RUN SHALL abort the operation without producing a done pulse.
REQ-025 The first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The bit-slice SHALL be one instance of the team's existing combinational full_adder (A, B, Cin, Sum, Cout); no other sub-module.

Verification (WIDTH=8)
REQ-028 Reset, then idle with start=0 -> sum=0x00, cout=0, busy=0, done=0 indefinitely.
REQ-029 start with a=0x55, b=0xAA, cin=1 -> busy high 8 cycles, then done pulses once, sum=0x00, cout=1.
REQ-030 Ops 0xFF+0x01+0 and then 0x12+0x34+0 -> first gives sum=0x00 with cout=1, second gives sum=0x46 with cout=0; results hold between ops.
REQ-031 Start 0x01+0x01+0, then pulse start with 0xFF+0xFF on the 3rd RUN cycle -> sum=0x02, cout=0, one done only.
REQ-032 rst_n low on the 4th RUN cycle of 0xF0+0x0F -> outputs zero immediately and no done; a following start of 0x0F+0x01+0 gives sum=0x10.
REQ-033 start held high for 3 ops -> done pulses exactly 10 cycles apart, each result correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the serial bit-slice.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit per cycle, LSB first.
// Handshake: start is accepted only in IDLE (busy=0, done=0); the result is
// valid on sum/cout in the cycle done is high and holds until the next result.
// state_dbg mirrors the FSM state for checkers.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       state_dbg
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, next_state;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum, fa_cout;
   logic             last_bit;

   assign last_bit  = (cnt == LAST);
   assign state_dbg = state;

   full_adder u_fa (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .Cin  (carry),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   // Sum shift register advance: new bit enters at the MSB (works for WIDTH=1).
   always_comb begin
      s_next            = s_sh >> 1;
      s_next[WIDTH-1]   = fa_sum;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // FSM next-state and status outputs; DONE always falls back to IDLE.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) next_state = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, shift one bit per RUN cycle,
   // load the visible result on the final bit so done and sum appear together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  carry <= cin;
                  s_sh  <= '0;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_next;
               carry <= fa_cout;
               cnt   <= cnt + CW'(1);
               if (last_bit) begin
                  sum  <= s_next;
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) with a scoreboard queue.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a_in, b_in;
   logic         cin;
   logic         busy, done, cout;
   logic [W-1:0] sum;
   logic [1:0]   state_dbg;

   logic [W:0]   exp_q[$];
   int           n_checks = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           n_done   = 0;
   bit           chk_spacing = 0;

   // Monitor-private state.
   logic [W:0]   held = '0;
   int           busy_len = 0;
   int           prev_cyc = 0;
   bit           have_prev = 0;
   logic         last_done = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a_in      (a_in),
      .b_in      (b_in),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .state_dbg (state_dbg)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: plain (W+1)-bit arithmetic, {cout, sum}.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while ((busy || done) && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: timeout busy=%0b done=%0b", busy, done);
      end
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      wait_idle();
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      cin   = c;
      @(posedge clk);
      #1 start = 1'b0;
      exp_q.push_back(model(a, b, c));
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      wait_idle();
   endtask

   // Monitor: pops the scoreboard on each done and checks hold/latency/pulse.
   always @(negedge clk) begin
      logic [W:0] e;
      if (!rst_n) begin
         held      = '0;
         busy_len  = 0;
         have_prev = 0;
         last_done = 0;
      end else begin
         if (done) begin
            chk("done_not_busy", {31'd0, busy}, 0);
            chk("done_single_pulse", {31'd0, last_done}, 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got sum=0x%0h cout=%0b with nothing expected", sum, cout);
            end else begin
               e = exp_q.pop_front();
               chk("result", {23'd0, cout, sum}, {23'd0, e});
               held = e;
            end
            chk("busy_cycles", busy_len, W);
            if (chk_spacing && have_prev) chk("done_spacing", cyc - prev_cyc, W + 2);
            have_prev = chk_spacing;
            prev_cyc  = cyc;
            busy_len  = 0;
            n_done++;
         end else begin
            chk("result_hold", {23'd0, cout, sum}, {23'd0, held});
            if (busy) busy_len++;
         end
         last_done = done;
      end
   end

   // Stimulus.
   initial begin
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      cin   = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset: everything stays zero.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         chk("idle_sum", {24'd0, sum}, 0);
         chk("idle_cout", {31'd0, cout}, 0);
         chk("idle_busy", {31'd0, busy}, 0);
         chk("idle_done", {31'd0, done}, 0);
      end

      // Directed cases.
      start_op(8'h55, 8'hAA, 1'b1);
      drain();
      start_op(8'hFF, 8'h01, 1'b0);
      drain();
      repeat (5) @(negedge clk);
      start_op(8'h12, 8'h34, 1'b0);
      drain();

      // Start pulse during RUN must be ignored.
      start_op(8'h01, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      start = 1'b1;
      a_in  = 8'hFF;
      b_in  = 8'hFF;
      @(posedge clk);
      #1 start = 1'b0;
      drain();
      repeat (10) @(negedge clk);

      // Reset in the 4th RUN cycle aborts with no done.
      start_op(8'hF0, 8'h0F, 1'b0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sum", {24'd0, sum}, 0);
      chk("rst_cout", {31'd0, cout}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      start_op(8'h0F, 8'h01, 1'b0);
      drain();

      // start held high for three operations.
      wait_idle();
      chk_spacing = 1'b1;
      start = 1'b1;
      a_in = 8'h80; b_in = 8'h80; cin = 1'b1;
      @(posedge clk);
      #1 exp_q.push_back(model(8'h80, 8'h80, 1'b1));
      a_in = 8'h3C; b_in = 8'h0A; cin = 1'b0;
      exp_q.push_back(model(8'h3C, 8'h0A, 1'b0));
      repeat (W + 2) @(posedge clk);
      #1 a_in = 8'hFE; b_in = 8'h01; cin = 1'b1;
      exp_q.push_back(model(8'hFE, 8'h01, 1'b1));
      repeat (W + 2) @(posedge clk);
      #1 start = 1'b0;
      drain();
      chk_spacing = 1'b0;

      // Randomized operations with random idle gaps.
      for (int i = 0; i < 25; i++) begin
         start_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      drain();

      repeat (10) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
